// File: rtl/ntt_bitrev_reorder_buf.sv
// Ping-pong streaming reorder buffer: frames written in natural order, read in LOG_N-bit bit-reversed order.
// Optional REORDER_FRAME_CNT_EN adds a 16-bit frames_done counter of completed output frames.
module ntt_bitrev_reorder_buf #(
  parameter int DATA_W = 8,
  parameter int LOG_N  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [LOG_N-1:0]  out_idx,
  output logic              out_last
`ifdef REORDER_FRAME_CNT_EN
  ,
  output logic [15:0]       frames_done
`endif
);

  localparam int N = 2 ** LOG_N;
  localparam logic [LOG_N-1:0] CNT_LAST = '1;

  // Bank b occupies mem_reg[b*N +: N]; the address is simply {bank, index}.
  logic [DATA_W-1:0] mem_reg [0:2*N-1];

  logic [1:0]       full_reg, full_next;
  logic             wr_bank_reg, wr_bank_next;
  logic             rd_bank_reg, rd_bank_next;
  logic [LOG_N-1:0] wr_cnt_reg, wr_cnt_next;
  logic [LOG_N-1:0] rd_cnt_reg, rd_cnt_next;
  logic [LOG_N-1:0] rd_idx;

  logic wr_fire, rd_fire, wr_done, rd_done;

  for (genvar gi = 0; gi < LOG_N; gi++) begin : g_bitrev
    assign rd_idx[gi] = rd_cnt_reg[LOG_N-1-gi];
  end

  assign in_ready  = ~full_reg[wr_bank_reg];
  assign out_valid = full_reg[rd_bank_reg];
  assign out_last  = out_valid && (rd_cnt_reg == CNT_LAST);
  assign out_idx   = out_valid ? rd_idx : '0;
  assign out_data  = out_valid ? mem_reg[{rd_bank_reg, rd_idx}] : '0;

  assign wr_fire = in_valid && in_ready;
  assign rd_fire = out_valid && out_ready;
  assign wr_done = wr_fire && (wr_cnt_reg == CNT_LAST);
  assign rd_done = rd_fire && (rd_cnt_reg == CNT_LAST);

  always_comb begin
    full_next    = full_reg;
    wr_bank_next = wr_bank_reg;
    rd_bank_next = rd_bank_reg;
    wr_cnt_next  = wr_cnt_reg;
    rd_cnt_next  = rd_cnt_reg;
    if (wr_fire) begin
      wr_cnt_next = wr_cnt_reg + 1'b1;
    end
    if (rd_fire) begin
      rd_cnt_next = rd_cnt_reg + 1'b1;
    end
    // Writes target only empty banks and reads only full ones, so these never collide.
    if (wr_done) begin
      full_next[wr_bank_reg] = 1'b1;
      wr_bank_next           = ~wr_bank_reg;
    end
    if (rd_done) begin
      full_next[rd_bank_reg] = 1'b0;
      rd_bank_next           = ~rd_bank_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_reg    <= '0;
      wr_bank_reg <= 1'b0;
      rd_bank_reg <= 1'b0;
      wr_cnt_reg  <= '0;
      rd_cnt_reg  <= '0;
    end else begin
      full_reg    <= full_next;
      wr_bank_reg <= wr_bank_next;
      rd_bank_reg <= rd_bank_next;
      wr_cnt_reg  <= wr_cnt_next;
      rd_cnt_reg  <= rd_cnt_next;
    end
  end

  // Coefficient storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_reg[{wr_bank_reg, wr_cnt_reg}] <= in_data;
    end
  end

`ifdef REORDER_FRAME_CNT_EN
  logic [15:0] frames_done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      frames_done_reg <= '0;
    end else if (rd_fire && out_last) begin
      frames_done_reg <= frames_done_reg + 16'd1;
    end
  end

  assign frames_done = frames_done_reg;
`endif

endmodule

// File: tb/tb_ntt_bitrev_reorder_buf.sv
// Directed bench for ntt_bitrev_reorder_buf with a reordering scoreboard.
// Define REORDER_FRAME_CNT_EN to also cover the frames_done counter.
module tb_ntt_bitrev_reorder_buf;

  localparam int DATA_W = 8;
  localparam int LOG_N  = 3;
  localparam int N      = 8;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [LOG_N-1:0]  out_idx;
  logic              out_last;
`ifdef REORDER_FRAME_CNT_EN
  logic [15:0]       frames_done;
`endif

  ntt_bitrev_reorder_buf #(.DATA_W(DATA_W), .LOG_N(LOG_N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
`ifdef REORDER_FRAME_CNT_EN
    ,
    .frames_done (frames_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [LOG_N-1:0]  idx;
    logic              last;
  } exp_t;

  exp_t              q[$];
  logic [DATA_W-1:0] src[$];
  logic [DATA_W-1:0] fb[$];
  logic [15:0]       fd_model;
  int                checks;
  int                errors;
  int                mode;
  int                cyc;

  function automatic logic [LOG_N-1:0] bitrev(input int k);
    logic [LOG_N-1:0] r;
    r = '0;
    for (int b = 0; b < LOG_N; b++) begin
      r[LOG_N-1-b] = k[b];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive just after negedge, check before posedge, advance the model.
  task automatic step();
    exp_t e;
    logic exp_in_ready;
    in_valid = (src.size() != 0);
    in_data  = in_valid ? src[0] : '0;
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = (cyc % 2 == 0);
    endcase
    cyc++;
    #1;
    exp_in_ready = ((q.size() + N - 1) / N) < 2;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_in_ready});
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      e = q[0];
      chk("out_data", {24'd0, out_data}, {24'd0, e.d});
      chk("out_idx", {29'd0, out_idx}, {29'd0, e.idx});
      chk("out_last", {31'd0, out_last}, {31'd0, e.last});
    end else begin
      chk("out_data_gated", {24'd0, out_data}, 32'd0);
      chk("out_idx_gated", {29'd0, out_idx}, 32'd0);
      chk("out_last_gated", {31'd0, out_last}, 32'd0);
    end
`ifdef REORDER_FRAME_CNT_EN
    chk("frames_done", {16'd0, frames_done}, {16'd0, fd_model});
`endif
    if (q.size() != 0 && out_ready) begin
      if (q[0].last) fd_model = fd_model + 16'd1;
      void'(q.pop_front());
    end
    if (in_valid && exp_in_ready) begin
      fb.push_back(src.pop_front());
      if (fb.size() == N) begin
        for (int k = 0; k < N; k++) begin
          e.idx  = bitrev(k);
          e.d    = fb[e.idx];
          e.last = (k == N - 1);
          q.push_back(e);
        end
        fb.delete();
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((src.size() != 0 || q.size() != 0) && n < limit) begin
      step();
      n++;
    end
    chk("drain_left", src.size() + q.size(), 32'd0);
  endtask

  task automatic push_frame(input logic [DATA_W-1:0] base);
    for (int i = 0; i < N; i++) src.push_back(base + DATA_W'(i));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    src.delete();
    fb.delete();
    fd_model = '0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
`ifdef REORDER_FRAME_CNT_EN
    chk("rst_frames_done", {16'd0, frames_done}, 32'd0);
`endif
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    mode      = 0;
    cyc       = 0;
    fd_model  = '0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    do_reset();

    // Single frame, natural 0..7 in
    mode = 0;
    push_frame(8'h00);
    drain(40);

    // Back-to-back frames with both sides always ready
    push_frame(8'h10);
    push_frame(8'h20);
    drain(60);

    // Backpressure: three frames offered while output is blocked
    mode = 1;
    push_frame(8'h00);
    push_frame(8'h08);
    push_frame(8'h10);
    repeat (30) step();
    #1;
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("bp_out_hold", {24'd0, out_data}, 32'h00);
    chk("bp_third_frame_pending", src.size(), N);
    mode = 0;
    drain(80);

    // Throttled output, ready toggling
    mode = 2;
    push_frame(8'h50);
    drain(60);

    // Mid-frame reset discards a partial frame
    mode = 0;
    for (int i = 0; i < 5; i++) src.push_back(8'h60 + 8'(i));
    repeat (5) step();
    do_reset();
    push_frame(8'h30);
    drain(40);

    // Two more frames, then frame counter and final reset
    push_frame(8'h40);
    push_frame(8'h48);
    drain(60);
`ifdef REORDER_FRAME_CNT_EN
    #1;
    chk("frames_done_three", {16'd0, frames_done}, 32'd3);
`endif
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
